// File: rtl/softmax_pkg.sv
// ---------------------------------------------------------------------------
// softmax_pkg : shared types and bus widths for the softmax sequencer/core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package softmax_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int c_num_inputs   = 4;
  localparam int c_exp_width    = 4;
  localparam int c_mant_width   = 3;
  localparam int c_core_latency = 2;
  localparam int c_word_w       = c_exp_width + c_mant_width;
  localparam int c_core_in_w    = c_num_inputs * c_word_w;
  localparam int c_core_exp_w   = c_num_inputs * c_exp_width;

  function automatic int lane_lo(input int lane, input int word_w);
    return lane * word_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/softmax_sequencer_latency_counter.sv
// ---------------------------------------------------------------------------
// latency_counter : loadable down-counter that stops at zero
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module latency_counter
  import softmax_pkg::*;
#(
  parameter int LOAD_VALUE = c_core_latency,
  localparam int CNT_W     = $clog2(LOAD_VALUE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LOAD_VALUE);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/softmax_sequencer.sv
// ---------------------------------------------------------------------------
// softmax_sequencer : serial element packer, core-latency wait, result buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module softmax_sequencer
  import softmax_pkg::*;
#(
  parameter int NUM_INPUTS   = c_num_inputs,
  parameter int EXP_WIDTH    = c_exp_width,
  parameter int MANT_WIDTH   = c_mant_width,
  parameter int CORE_LATENCY = c_core_latency,
  localparam int WORD_W      = EXP_WIDTH + MANT_WIDTH,
  localparam int IDX_W       = $clog2(NUM_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_W-1:0]               in_data,
  input  logic                            in_last,
  output logic [NUM_INPUTS*WORD_W-1:0]    core_in,
  input  logic [MANT_WIDTH-1:0]           core_mant,
  input  logic [NUM_INPUTS*EXP_WIDTH-1:0] core_exp,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MANT_WIDTH-1:0]           out_mant,
  output logic [NUM_INPUTS*EXP_WIDTH-1:0] out_exp,
  output logic                            out_err,
  output logic                            busy
);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic [NUM_INPUTS*WORD_W-1:0]    r_lanes;
  logic                            r_err;
  logic                            r_out_valid;
  logic                            r_out_err;
  logic [MANT_WIDTH-1:0]           r_out_mant;
  logic [NUM_INPUTS*EXP_WIDTH-1:0] r_out_exp;

  logic w_accept;
  logic w_last_lane;
  logic w_close;
  logic w_cnt_zero;
  logic w_capture;
  logic w_deliver;

  assign w_accept    = in_valid && (r_state == FILL);
  assign w_last_lane = (r_idx == IDX_W'(NUM_INPUTS - 1));
  assign w_close     = w_accept && (in_last || w_last_lane);
  assign w_capture   = (r_state == RUN) && w_cnt_zero;
  // r_out_valid is only ever set while in HOLD
  assign w_deliver   = r_out_valid && out_ready;

  latency_counter #(
    .LOAD_VALUE (CORE_LATENCY)
  ) u_latency_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_close),
    .i_dec  (r_state == RUN),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (w_close) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_cnt_zero) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_lanes     <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
    end else begin
      if (w_accept) begin
        // On close, every lane above the written one is zero-padded
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (IDX_W'(i) == r_idx) begin
            r_lanes[lane_lo(i, WORD_W) +: WORD_W] <= in_data;
          end else if (w_close && (IDX_W'(i) > r_idx)) begin
            r_lanes[lane_lo(i, WORD_W) +: WORD_W] <= '0;
          end
        end
        r_idx <= w_close ? '0 : r_idx + IDX_W'(1);
        if (w_close) r_err <= w_last_lane && !in_last;
      end
      if (w_capture) begin
        r_out_mant  <= core_mant;
        r_out_exp   <= core_exp;
        r_out_err   <= r_err;
        r_out_valid <= 1'b1;
      end else if (w_deliver) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign core_in   = r_lanes;
  assign out_valid = r_out_valid;
  assign out_mant  = r_out_mant;
  assign out_exp   = r_out_exp;
  assign out_err   = r_out_err;
  assign busy      = (r_state != FILL) || (r_idx != '0);

endmodule

`default_nettype wire

// File: tb/tb_softmax_sequencer.sv
// ---------------------------------------------------------------------------
// tb_softmax_sequencer : randomized scenarios against a vector-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_softmax_sequencer;

  localparam int N   = 4;
  localparam int EW  = 4;
  localparam int MW  = 3;
  localparam int CL  = 2;
  localparam int WW  = EW + MW;
  localparam int CIW = N * WW;
  localparam int CEW = N * EW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [WW-1:0]  in_data = '0;
  logic           in_last = 1'b0;
  logic [CIW-1:0] core_in;
  logic [MW-1:0]  core_mant;
  logic [CEW-1:0] core_exp;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [MW-1:0]  out_mant;
  logic [CEW-1:0] out_exp;
  logic           out_err;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  softmax_sequencer #(
    .NUM_INPUTS   (N),
    .EXP_WIDTH    (EW),
    .MANT_WIDTH   (MW),
    .CORE_LATENCY (CL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .core_in   (core_in),
    .core_mant (core_mant),
    .core_exp  (core_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_err   (out_err),
    .busy      (busy)
  );

  // Stand-in core: an arbitrary deterministic function of the input vector
  function automatic logic [MW-1:0] core_mant_fn(input logic [CIW-1:0] v);
    logic [MW-1:0] s;
    s = MW'(3);
    for (int i = 0; i < N; i++) s = s + v[i*WW +: MW];
    return s;
  endfunction

  function automatic logic [CEW-1:0] core_exp_fn(input logic [CIW-1:0] v);
    logic [CEW-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) e[i*EW +: EW] = v[i*WW+MW +: EW] + EW'(i + 1);
    return e;
  endfunction

  assign core_mant = core_mant_fn(core_in);
  assign core_exp  = core_exp_fn(core_in);

  // Vector-level model: elements gather until last or N, then zero-pad
  logic [WW-1:0] mdl_q[$];

  task automatic model_push(input logic [WW-1:0] d, input bit last,
                            output bit closed, output logic [CIW-1:0] vec,
                            output bit err);
    mdl_q.push_back(d);
    closed = last || (mdl_q.size() == N);
    vec = '0;
    err = 1'b0;
    if (closed) begin
      for (int i = 0; i < mdl_q.size(); i++) vec[i*WW +: WW] = mdl_q[i];
      err = (mdl_q.size() == N) && !last;
      mdl_q.delete();
    end
  endtask

  task automatic feed(input logic [WW-1:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_mant !== '0) begin n_err++; $display("FAIL rst_out_mant: got %h want 0", out_mant); end
    n_cmp++; if (out_exp !== '0) begin n_err++; $display("FAIL rst_out_exp: got %h want 0", out_exp); end
    n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL rst_out_err: got %0b want 0", out_err); end
    n_cmp++; if (core_in !== '0) begin n_err++; $display("FAIL rst_core_in: got %h want 0", core_in); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rst_release: in_ready=%0b busy=%0b want 1/0", in_ready, busy); end
  endtask

  task automatic test_full_vector;
    logic [WW-1:0]  d;
    logic [CIW-1:0] vec;
    bit closed, err;
    int cyc;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      d = WW'($urandom);
      model_push(d, k == N - 1, closed, vec, err);
      feed(d, k == N - 1);
    end
    wait_valid(cyc);
    n_cmp++; if (cyc !== CL + 1) begin n_err++; $display("FAIL full_latency: got %0d edges want %0d", cyc, CL + 1); end
    n_cmp++; if (core_in !== vec) begin n_err++; $display("FAIL full_core_in: got %h want %h", core_in, vec); end
    n_cmp++; if (out_mant !== core_mant_fn(vec)) begin n_err++; $display("FAIL full_mant: got %h want %h", out_mant, core_mant_fn(vec)); end
    n_cmp++; if (out_exp !== core_exp_fn(vec)) begin n_err++; $display("FAIL full_exp: got %h want %h", out_exp, core_exp_fn(vec)); end
    n_cmp++; if (out_err !== err) begin n_err++; $display("FAIL full_err: got %0b want %0b", out_err, err); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_hold_ready: got %0b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL full_handshake: out_valid=%0b in_ready=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_short_vector;
    logic [WW-1:0]  d;
    logic [CIW-1:0] vec;
    bit closed, err;
    int cyc;
    for (int k = 0; k < 2; k++) begin
      d = WW'($urandom) | WW'(1);
      model_push(d, k == 1, closed, vec, err);
      feed(d, k == 1);
    end
    wait_valid(cyc);
    n_cmp++; if (core_in[2*WW +: 2*WW] !== '0) begin n_err++; $display("FAIL short_pad: got %h want 0", core_in[2*WW +: 2*WW]); end
    n_cmp++; if (core_in !== vec) begin n_err++; $display("FAIL short_core_in: got %h want %h", core_in, vec); end
    n_cmp++; if (out_mant !== core_mant_fn(vec) || out_exp !== core_exp_fn(vec)) begin
      n_err++; $display("FAIL short_result: got %h/%h want %h/%h", out_mant, out_exp, core_mant_fn(vec), core_exp_fn(vec));
    end
    n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL short_err: got %0b want 0", out_err); end
    @(negedge clk);
  endtask

  task automatic test_missing_last;
    logic [WW-1:0]  d;
    logic [CIW-1:0] vec;
    bit closed, err;
    int cyc;
    for (int k = 0; k < N; k++) begin
      d = WW'($urandom);
      model_push(d, 1'b0, closed, vec, err);
      feed(d, 1'b0);
    end
    wait_valid(cyc);
    n_cmp++; if (out_err !== 1'b1 || err !== 1'b1) begin n_err++; $display("FAIL miss_err: got %0b want 1", out_err); end
    n_cmp++; if (core_in !== vec || out_mant !== core_mant_fn(vec)) begin
      n_err++; $display("FAIL miss_result: core_in=%h mant=%h want %h/%h", core_in, out_mant, vec, core_mant_fn(vec));
    end
    @(negedge clk);
    d = WW'($urandom);
    model_push(d, 1'b0, closed, vec, err);
    feed(d, 1'b0);
    n_cmp++; if (core_in[0 +: WW] !== d || busy !== 1'b1) begin
      n_err++; $display("FAIL miss_next_lane0: lane0=%h busy=%0b want %h/1", core_in[0 +: WW], busy, d);
    end
    d = WW'($urandom);
    model_push(d, 1'b1, closed, vec, err);
    feed(d, 1'b1);
    wait_valid(cyc);
    n_cmp++; if (core_in !== vec || out_exp !== core_exp_fn(vec) || out_err !== 1'b0) begin
      n_err++; $display("FAIL miss_next_vec: core_in=%h exp=%h err=%0b want %h/%h/0", core_in, out_exp, out_err, vec, core_exp_fn(vec));
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [WW-1:0]  d;
    logic [CIW-1:0] vec;
    bit closed, err;
    int cyc;
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      d = WW'($urandom);
      model_push(d, k == N - 1, closed, vec, err);
      feed(d, k == N - 1);
    end
    wait_valid(cyc);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = WW'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold: cycle %0d out_valid=%0b in_ready=%0b want 1/0", c, out_valid, in_ready);
      end
      n_cmp++; if (out_mant !== core_mant_fn(vec) || out_exp !== core_exp_fn(vec) || out_err !== 1'b0) begin
        n_err++; $display("FAIL bp_stable: cycle %0d got %h/%h/%0b want %h/%h/0", c, out_mant, out_exp, out_err, core_mant_fn(vec), core_exp_fn(vec));
      end
      n_cmp++; if (core_in !== vec) begin n_err++; $display("FAIL bp_core_in: cycle %0d got %h want %h", c, core_in, vec); end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_inflight;
    logic [WW-1:0]  d;
    logic [CIW-1:0] vec;
    bit closed, err;
    int cyc;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      d = WW'($urandom);
      model_push(d, k == N - 1, closed, vec, err);
      feed(d, k == N - 1);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      in_valid = 1'($urandom);
      in_data  = WW'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      cyc++;
      n_cmp++; if (core_in !== vec || in_ready !== 1'b0) begin
        n_err++; $display("FAIL inflight_core_in: got %h ready=%0b want %h/0", core_in, in_ready, vec);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_mant !== core_mant_fn(vec) || out_exp !== core_exp_fn(vec)) begin
      n_err++; $display("FAIL inflight_result: valid=%0b got %h/%h want %h/%h", out_valid, out_mant, out_exp, core_mant_fn(vec), core_exp_fn(vec));
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL inflight_no_accept: busy=%0b want 0", busy); end
  endtask

  task automatic test_async_reset;
    logic [WW-1:0]  d;
    logic [CIW-1:0] vec;
    bit closed, err;
    int cyc;
    for (int k = 0; k < N; k++) begin
      d = WW'($urandom) | WW'(1);
      model_push(d, k == N - 1, closed, vec, err);
      feed(d, k == N - 1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (core_in !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL arst_clear: core_in=%h busy=%0b in_ready=%0b want 0/0/1", core_in, busy, in_ready);
    end
    n_cmp++; if (out_valid !== 1'b0 || out_mant !== '0 || out_exp !== '0 || out_err !== 1'b0) begin
      n_err++; $display("FAIL arst_out: valid=%0b mant=%h exp=%h err=%0b want all 0", out_valid, out_mant, out_exp, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_q.delete();
    for (int c = 0; c < CL + 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_no_pulse: cycle %0d out_valid=%0b want 0", c, out_valid); end
    end
    for (int k = 0; k < N; k++) begin
      d = WW'($urandom);
      model_push(d, k == N - 1, closed, vec, err);
      feed(d, k == N - 1);
    end
    wait_valid(cyc);
    n_cmp++; if (cyc !== CL + 1 || out_mant !== core_mant_fn(vec) || out_exp !== core_exp_fn(vec)) begin
      n_err++; $display("FAIL arst_after: lat=%0d got %h/%h want %0d %h/%h", cyc, out_mant, out_exp, CL + 1, core_mant_fn(vec), core_exp_fn(vec));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [WW-1:0]  d;
    logic [CIW-1:0] vec;
    bit closed, err, last;
    int cyc;
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      d    = WW'($urandom);
      last = ($urandom_range(0, 3) == 0) || (k == 29);
      model_push(d, last, closed, vec, err);
      feed(d, last);
      if (closed) begin
        wait_valid(cyc);
        n_cmp++; if (out_valid !== 1'b1 || cyc !== CL + 1) begin
          n_err++; $display("FAIL b2b_valid: elem %0d valid=%0b lat=%0d want 1/%0d", k, out_valid, cyc, CL + 1);
        end
        n_cmp++; if (core_in !== vec || out_mant !== core_mant_fn(vec) || out_exp !== core_exp_fn(vec) || out_err !== err) begin
          n_err++; $display("FAIL b2b_result: elem %0d core_in=%h %h/%h/%0b want %h %h/%h/%0b",
                            k, core_in, out_mant, out_exp, out_err, vec, core_mant_fn(vec), core_exp_fn(vec), err);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_short_vector();
    test_missing_last();
    test_backpressure();
    test_inflight();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
